// File: rtl/add64_byte_seq.sv
// rtl/add64_byte_seq.sv - W-bit adder that reuses one external 8-bit adder, one byte per cycle
module add64_byte_seq #(
    parameter int NBYTES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic [7:0]          sa,
    output logic [7:0]          sb,
    output logic                s_cin,
    input  logic [7:0]          s_sum,
    input  logic                s_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            cin_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;

    // The external adder is combinational, so its operands come straight from
    // the latched operands and the current byte index.
    always_comb begin
        sa    = 8'd0;
        sb    = 8'd0;
        s_cin = 1'b0;
        if (state == RUN) begin
            sa    = a_reg[8*idx +: 8];
            sb    = b_reg[8*idx +: 8];
            s_cin = (idx == '0) ? cin_reg : carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            cin_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        cin_reg  <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    sum[8*idx +: 8] <= s_sum;
                    carry           <= s_cout;
                    if (idx == LAST) begin
                        // Sign of the result is bit 7 of the top byte just produced.
                        cout      <= s_cout;
                        ovf       <= (a_reg[W-1] == b_reg[W-1]) && (s_sum[7] != a_reg[W-1]);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add64_byte_seq.sv
// tb/tb_add64_byte_seq.sv - directed scoreboard bench for add64_byte_seq
module tb_add64_byte_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        cin;
    logic [7:0]  sa, sb;
    logic        s_cin;
    logic [7:0]  s_sum;
    logic        s_cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [65:0] exp_q[$];
    logic        scin_log[0:15];
    int          lat;

    always #5 clk = ~clk;

    // External 8-bit adder
    assign {s_cout, s_sum} = {1'b0, sa} + {1'b0, sb} + {8'd0, s_cin};

    add64_byte_seq #(.NBYTES(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sa(sa), .sb(sb), .s_cin(s_cin),
        .s_sum(s_sum), .s_cout(s_cout), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one operand set for one edge; expected result goes on the scoreboard.
    task automatic send(input logic [63:0] ta, input logic [63:0] tb_, input logic tc);
        logic [64:0] full;
        logic        o;
        full = {1'b0, ta} + {1'b0, tb_} + {64'd0, tc};
        o = (ta[63] == tb_[63]) && (full[63] != ta[63]);
        exp_q.push_back({full[63:0], full[64], o});
        chk("accept_ready", {79'd0, in_ready}, 80'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom(); b = $urandom(); cin = 1'b0;
    endtask

    // Wait for out_valid while logging s_cin per byte, then compare with the scoreboard.
    task automatic collect(input string tag);
        logic [65:0] e;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (lat < 16) scin_log[lat] = s_cin;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 80'(lat), 80'd8);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 80'd0, 80'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"},  {16'd0, sum}, {16'd0, e[65:2]});
            chk({tag, "_cout"}, {79'd0, cout}, {79'd0, e[1]});
            chk({tag, "_ovf"},  {79'd0, ovf},  {79'd0, e[0]});
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] held_sum;
        logic        held_c, held_o;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready",  {79'd0, in_ready},  80'd1);
        chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
        chk("rst_sum",       {16'd0, sum},       80'd0);
        chk("rst_cout_ovf",  {78'd0, cout, ovf}, 80'd0);
        chk("rst_s_ports",   {63'd0, sa, sb, s_cin}, 80'd0);

        // Case 1: full carry ripple
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        collect("c1");
        consume();
        chk("c1_idle_ready", {79'd0, in_ready}, 80'd1);
        chk("c1_idle_hold",  {16'd0, sum}, 80'd0);
        chk("c1_idle_cout",  {79'd0, cout}, 80'd1);

        // Case 2: signed overflow
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        collect("c2");
        consume();

        // Case 3: carry into byte 1
        send(64'h00FF, 64'h0001, 1'b0);
        collect("c3");
        chk("c3_scin_idx0", {79'd0, scin_log[0]}, 80'd0);
        chk("c3_scin_idx1", {79'd0, scin_log[1]}, 80'd1);
        chk("c3_scin_idx2", {79'd0, scin_log[2]}, 80'd0);
        consume();

        // Case 4: carry-in only used at byte 0
        send(64'd0, 64'd0, 1'b1);
        collect("c4");
        for (int i = 0; i < 8; i++)
            chk($sformatf("c4_scin_idx%0d", i), {79'd0, scin_log[i]}, (i == 0) ? 80'd1 : 80'd0);
        consume();

        // Case 5: back-pressure in DONE while new operands are offered
        send(64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001, 1'b1);
        collect("c5");
        held_sum = 64'h1234_5678_9ABC_DEF0 + 64'h8000_0000_0000_0001 + 64'd1;
        held_c = 1'b0;
        held_o = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 64'hDEAD_BEEF_0000_0000 + 64'(i); b = 64'h5555; cin = 1'b1; in_valid = 1'b1;
            tick();
            chk("c5_hold_sum",   {16'd0, sum}, {16'd0, held_sum});
            chk("c5_hold_flags", {78'd0, cout, ovf}, {78'd0, held_c, held_o});
            chk("c5_in_ready",   {79'd0, in_ready}, 80'd0);
            chk("c5_out_valid",  {79'd0, out_valid}, 80'd1);
        end
        in_valid = 1'b0;
        consume();
        for (int i = 0; i < 10; i++) tick();
        chk("c5_no_extra_result", {79'd0, out_valid}, 80'd0);
        chk("c5_sb_drained", 80'(exp_q.size()), 80'd0);

        // Case 6: reset mid-transaction at idx=3
        send(64'h0F0F_0F0F_0F0F_0F0F, 64'h0101_0101_0101_0101, 1'b0);
        tick(); tick(); tick();
        void'(exp_q.pop_front());
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("c6_in_ready",  {79'd0, in_ready},  80'd1);
        chk("c6_out_valid", {79'd0, out_valid}, 80'd0);
        chk("c6_sum",       {16'd0, sum},       80'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("c6_no_result", {79'd0, out_valid}, 80'd0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        collect("c6_after");
        consume();

        // A few random operand sets
        for (int i = 0; i < 4; i++) begin
            send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            collect($sformatf("rnd%0d", i));
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
